// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: size encodings, FSM states,
// default geometry and the alignment predicate.
package dmem_pkg;

    localparam int DEF_DEPTH = 256;
    localparam int DEF_IW    = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RD   = 1'b1
    } state_e;

    // Reserved size behaves as word, so it shares the word alignment rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            default: return (lane != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts a byte, halfword or word from a 32-bit memory word and extends it
// to 32 bits. Half ignores lane[0]; word and reserved sizes ignore the lane.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and zero/sign extension.
    always_comb begin
        byte_s = word[{lane, 3'b000} +: 8];
        half_s = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: data = sign ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s};
            SZ_HALF: data = sign ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data memory with valid/ready requests; stores complete at
// acceptance, loads return two cycles later. Optional DMEM_ALIGN_CHECK_EN.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IW    = DEF_IW
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_sign,
    input  logic [IW+1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rd_valid,
    output logic [31:0]   rd_data,
    output logic          misalign
);

    state_e         state_r;
    state_e         next_state_s;
    logic           accept_s;
    logic           st_accept_s;
    logic           ld_accept_s;
    logic           mis_s;
    logic [3:0]     be_s;
    logic [31:0]    wdata_rep_s;
    logic [IW-1:0]  idx_r;
    logic [1:0]     lane_r;
    logic [1:0]     size_r;
    logic           sign_r;
    logic           ld_mis_r;
    logic [31:0]    rd_word_s;
    logic [31:0]    aligned_s;
    logic [31:0]    mem_r [DEPTH];

    assign req_ready   = (state_r == ST_IDLE) && !reset;
    assign accept_s    = req_valid && req_ready;
`ifdef DMEM_ALIGN_CHECK_EN
    assign mis_s       = is_misaligned(req_size, req_addr[1:0]);
`else
    assign mis_s       = 1'b0;
`endif
    assign st_accept_s = accept_s && req_we && !mis_s;
    assign ld_accept_s = accept_s && !req_we;

    // Replicate store data across lanes so each lane enable picks the right bytes.
    always_comb begin
        case (req_size)
            SZ_BYTE: begin
                be_s        = 4'b0001 << req_addr[1:0];
                wdata_rep_s = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_s        = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep_s = {2{req_wdata[15:0]}};
            end
            default: begin
                be_s        = 4'b1111;
                wdata_rep_s = req_wdata;
            end
        endcase
    end

    // Memory array with per-lane writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (st_accept_s && be_s[i]) begin
                mem_r[req_addr[IW+1:2]][8*i +: 8] <= wdata_rep_s[8*i +: 8];
            end
        end
    end

    // Next-state logic: an accepted load spends one cycle in RD.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ld_accept_s) next_state_s = ST_RD;
                else             next_state_s = ST_IDLE;
            end
            ST_RD:   next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= next_state_s;
    end

    // Capture load attributes at acceptance for use in the RD cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r    <= '0;
            lane_r   <= 2'b00;
            size_r   <= SZ_BYTE;
            sign_r   <= 1'b0;
            ld_mis_r <= 1'b0;
        end else if (ld_accept_s) begin
            idx_r    <= req_addr[IW+1:2];
            lane_r   <= req_addr[1:0];
            size_r   <= req_size;
            sign_r   <= req_sign;
            ld_mis_r <= mis_s;
        end
    end

    assign rd_word_s = mem_r[idx_r];

    load_align u_load_align (
        .word (rd_word_s),
        .lane (lane_r),
        .size (size_r),
        .sign (sign_r),
        .data (aligned_s)
    );

    // Registered load result; rd_data holds between loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= 32'h0000_0000;
        end else begin
            rd_valid <= (state_r == ST_RD);
            if (state_r == ST_RD) begin
                rd_data <= ld_mis_r ? 32'h0000_0000 : aligned_s;
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic misalign_r;

    // Misalign pulse: cycle after a store, or alongside rd_valid for a load.
    always_ff @(posedge clk) begin
        if (reset) misalign_r <= 1'b0;
        else       misalign_r <= (accept_s && req_we && mis_s) ||
                                 ((state_r == ST_RD) && ld_mis_r);
    end

    assign misalign = misalign_r;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed, table-driven bench for dmem_ctrl with hand-written sequences for
// reset, back-to-back loads and reset during a load. Honours DMEM_ALIGN_CHECK_EN.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign = 1'b0;
    logic [9:0]  req_addr = 10'h000;
    logic [31:0] req_wdata = 32'h0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        misalign;

    int passed = 0;
    int total  = 0;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    dmem_ctrl #(.DEPTH(256), .IW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        mis;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sign,
                                input logic [9:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp, input logic mis, input string name);
        vec_t v;
        v.we = we; v.size = size; v.sign = sign; v.addr = addr;
        v.wdata = wdata; v.exp = exp; v.mis = mis; v.name = name;
        return v;
    endfunction

    task automatic drive(input logic we, input logic [1:0] size, input logic sign,
                         input logic [9:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    initial begin
        vec_t  v;
        logic  pend;
        logic  pend_mis;
        string pend_name;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_rd_valid", 32'(rd_valid), 32'd0);
            chk("rst_rd_data", rd_data, 32'h0000_0000);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("post_rst_misalign", 32'(misalign), 32'd0);
        @(posedge clk); #1;

        //           we    size   sgn   addr     wdata          expected        mis    name
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 10'h010, 32'h8C7F_1234, 32'h0, 1'b0, "st_w_010"));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'h8C7F_1234, 1'b0, "ld_w_010"));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 10'h013, 32'h0, 32'hFFFF_FF8C, 1'b0, "ld_bs_013"));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 10'h013, 32'h0, 32'h0000_008C, 1'b0, "ld_bu_013"));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 10'h012, 32'h0, 32'hFFFF_8C7F, 1'b0, "ld_hs_012"));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 10'h010, 32'h0, 32'h0000_1234, 1'b0, "ld_hu_010"));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 10'h011, 32'h0, 32'h0000_0012, 1'b0, "ld_bs_011"));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 10'h3FC, 32'h1122_3344, 32'h0, 1'b0, "st_w_3fc"));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 10'h3FD, 32'hFFFF_FFAB, 32'h0, 1'b0, "st_b_3fd"));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0, 32'h1122_AB44, 1'b0, "ld_w_3fc"));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 10'h3FE, 32'h1234_BEEF, 32'h0, 1'b0, "st_h_3fe"));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0, 32'hBEEF_AB44, 1'b0, "ld_w_3fc_b"));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 10'h3FE, 32'h0, 32'hFFFF_BEEF, 1'b0, "ld_hs_3fe"));
        vecs.push_back(mk(1'b1, 2'b11, 1'b0, 10'h020, 32'hCAFE_F00D, 32'h0, 1'b0, "st_rsv_020"));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 32'hCAFE_F00D, 1'b0, "ld_w_020"));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 10'h011, 32'h0,
                          ALIGN ? 32'h0 : 32'h8C7F_1234, ALIGN, "ld_w_011"));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 10'h013, 32'h0,
                          ALIGN ? 32'h0 : 32'h0000_8C7F, ALIGN, "ld_hu_013"));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 10'h021, 32'h0000_5555, 32'h0, ALIGN, "st_h_021"));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 10'h020, 32'h0,
                          ALIGN ? 32'hCAFE_F00D : 32'hCAFE_5555, 1'b0, "ld_w_020_b"));

        pend = 1'b0;
        pend_mis = 1'b0;
        pend_name = "";
        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v.we, v.size, v.sign, v.addr, v.wdata);
            @(negedge clk);
            if (pend) chk({pend_name, "_misalign"}, 32'(misalign), 32'(pend_mis));
            pend = 1'b0;
            chk({v.name, "_ready"}, 32'(req_ready), 32'd1);
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (v.we) begin
                pend      = 1'b1;
                pend_mis  = v.mis;
                pend_name = v.name;
            end else begin
                @(negedge clk);
                chk({v.name, "_busy"}, 32'(req_ready), 32'd0);
                chk({v.name, "_early"}, 32'(rd_valid), 32'd0);
                @(posedge clk); #1;
                @(negedge clk);
                chk({v.name, "_valid"}, 32'(rd_valid), 32'd1);
                chk({v.name, "_data"}, rd_data, v.exp);
                chk({v.name, "_misalign"}, 32'(misalign), 32'(v.mis));
                @(posedge clk); #1;
            end
        end
        if (pend) begin
            @(negedge clk);
            chk({pend_name, "_misalign"}, 32'(misalign), 32'(pend_mis));
            @(posedge clk); #1;
        end

        // Second load held pending while busy, accepted in C2 of the first.
        drive(1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 2'b00, 1'b0, 10'h3FD, 32'h0);
        @(negedge clk);
        chk("b2b_c1_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_a_valid", 32'(rd_valid), 32'd1);
        chk("b2b_a_data", rd_data, 32'hBEEF_AB44);
        chk("b2b_c2_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_c3_valid", 32'(rd_valid), 32'd0);
        chk("b2b_hold_data", rd_data, 32'hBEEF_AB44);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_b_valid", 32'(rd_valid), 32'd1);
        chk("b2b_b_data", rd_data, 32'h0000_00AB);
        @(posedge clk); #1;

        // Reset during RD abandons the load; a store presented under reset is dropped.
        drive(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rd_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("rst_rd_no_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data_clr", rd_data, 32'h0000_0000);
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rd_no_valid2", 32'(rd_valid), 32'd0);
        chk("rst_rd_ready_back", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_store_drop_valid", 32'(rd_valid), 32'd1);
        chk("rst_store_drop_data", rd_data, 32'h8C7F_1234);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
